// File: rtl/bsg_downstream_rx_pkg.sv
// bsg_downstream_rx_pkg: shared widths and assembler state for the downstream link receiver
package bsg_downstream_rx_pkg;
   localparam int CORE_WIDTH = 64;
   localparam int CH_WIDTH   = 16;
   localparam int NUM_CH     = 2;
   localparam int BEAT_WIDTH = NUM_CH * CH_WIDTH;
   typedef enum logic {LOW, HIGH} asm_state_e;
endpackage

// File: rtl/bsg_downstream_in_rx_if.sv
// bsg_downstream_in_rx_if: io-side beats, core-side valid/yumi and status of the link receiver
// BSG_DOWNSTREAM_RX_STATS_EN adds the word count and FIFO level signals
interface bsg_downstream_in_rx_if #(parameter int FIFO_DEPTH = 8);
   import bsg_downstream_rx_pkg::*;
   logic                  io_valid_ch0_i;
   logic [CH_WIDTH-1:0]   io_data_ch0_i;
   logic                  io_valid_ch1_i;
   logic [CH_WIDTH-1:0]   io_data_ch1_i;
   logic                  io_token_o;
   logic                  core_valid_o;
   logic [CORE_WIDTH-1:0] core_data_o;
   logic                  core_yumi_i;
   logic                  err_overflow_o;
   logic                  err_skew_o;
`ifdef BSG_DOWNSTREAM_RX_STATS_EN
   logic [15:0]                  rx_word_cnt_o;
   logic [$clog2(FIFO_DEPTH):0]  fifo_level_o;
`endif
   modport slave (
      input  io_valid_ch0_i, io_data_ch0_i, io_valid_ch1_i, io_data_ch1_i, core_yumi_i,
      output io_token_o, core_valid_o, core_data_o, err_overflow_o, err_skew_o
`ifdef BSG_DOWNSTREAM_RX_STATS_EN
      , output rx_word_cnt_o, fifo_level_o
`endif
   );
   modport master (
      output io_valid_ch0_i, io_data_ch0_i, io_valid_ch1_i, io_data_ch1_i, core_yumi_i,
      input  io_token_o, core_valid_o, core_data_o, err_overflow_o, err_skew_o
`ifdef BSG_DOWNSTREAM_RX_STATS_EN
      , input rx_word_cnt_o, fifo_level_o
`endif
   );
endinterface

// File: rtl/bsg_downstream_rx_fifo.sv
// bsg_downstream_rx_fifo: circular synchronous FIFO with extra-MSB pointers; push into a full
// FIFO succeeds only when a pop happens in the same cycle
module bsg_downstream_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr, rd;
   logic             wr_en, rd_en;
   assign empty = wr == rd;
   assign full  = (wr[AW-1:0] == rd[AW-1:0]) & (wr[AW] != rd[AW]);
   assign level = wr - rd;
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (wr_en) wr <= wr + 1'b1;
         if (rd_en) rd <= rd + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/bsg_downstream_in_rx.sv
// bsg_downstream_in_rx: reassembles two 32-bit channel beats into 64-bit words, buffers them and
// returns one token toggle per TOKEN_RATIO pops; BSG_DOWNSTREAM_RX_STATS_EN adds word count/level
module bsg_downstream_in_rx
   import bsg_downstream_rx_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TOKEN_RATIO = 4,
   parameter int CH_WIDTH    = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   bsg_downstream_in_rx_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = TOKEN_RATIO > 1 ? $clog2(TOKEN_RATIO) : 1;
   if (CH_WIDTH * NUM_CH * 2 != CORE_WIDTH) begin : g_bad_width
      $error("CH_WIDTH must give 2 channels x 2 beats = CORE_WIDTH");
   end
   if (FIFO_DEPTH % TOKEN_RATIO != 0) begin : g_bad_ratio
      $error("TOKEN_RATIO must divide FIFO_DEPTH");
   end
   asm_state_e             state, state_n;
   logic [BEAT_WIDTH-1:0]  low_q, payload;
   logic [CORE_WIDTH-1:0]  head;
   logic [AW:0]            level;
   logic [TW-1:0]          tok_cnt;
   logic                   beat, skew, capture, push_req, pop, full, empty, tok_last;
   logic                   token, err_ovf, err_skew;
   assign beat     = bus.io_valid_ch0_i & bus.io_valid_ch1_i;
   assign skew     = bus.io_valid_ch0_i ^ bus.io_valid_ch1_i;
   assign payload  = {bus.io_data_ch1_i, bus.io_data_ch0_i};
   assign pop      = bus.core_yumi_i & ~empty;
   assign tok_last = tok_cnt == TW'(TOKEN_RATIO - 1);
   always_ff @(posedge clk) begin
      if (!rst_n) state <= LOW;
      else state <= state_n;
   end
   always_comb begin
      state_n  = state;
      capture  = 1'b0;
      push_req = 1'b0;
      if (beat) begin
         state_n  = state == LOW ? HIGH : LOW;
         capture  = state == LOW;
         push_req = state == HIGH;
      end
   end
   bsg_downstream_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CORE_WIDTH)) fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .pop   (pop),
      .din   ({payload, low_q}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         low_q    <= '0;
         tok_cnt  <= '0;
         token    <= 1'b0;
         err_ovf  <= 1'b0;
         err_skew <= 1'b0;
      end else begin
         if (capture) low_q <= payload;
         if (pop) begin
            tok_cnt <= tok_last ? '0 : tok_cnt + 1'b1;
            token   <= token ^ tok_last;
         end
         err_skew <= err_skew | skew;
         err_ovf  <= err_ovf | (push_req & full & ~pop);
      end
   end
   // an empty FIFO presents zero rather than a stale slot
   assign bus.core_data_o    = level != '0 ? head : '0;
   assign bus.core_valid_o   = ~empty;
   assign bus.io_token_o     = token;
   assign bus.err_overflow_o = err_ovf;
   assign bus.err_skew_o     = err_skew;
`ifdef BSG_DOWNSTREAM_RX_STATS_EN
   logic [15:0] word_cnt;
   always_ff @(posedge clk) begin
      if (!rst_n) word_cnt <= '0;
      else if (push_req & (~full | pop) & ~&word_cnt) word_cnt <= word_cnt + 1'b1;
   end
   assign bus.rx_word_cnt_o = word_cnt;
   assign bus.fifo_level_o  = level;
`endif
endmodule

// File: doc/bsg_downstream_in_rx.md
Name: bsg_downstream_in_rx

Overview:
- Receive end of the BSG off-chip link; mirror of the upstream output path.
- Takes the two 16-bit channel beats already deserialized from the DDR pads in the io clock domain and reassembles them into 64-bit core words.
- Buffers the words in a small FIFO and presents them to the core through a valid/yumi handshake.
- Returns flow-control credit to the upstream transmitter as a toggling token line, one toggle per TOKEN_RATIO words consumed.

Parameters:
- FIFO_DEPTH, 8: words of receive buffering. Power of two, ≥ 2. Equals the upstream credit count.
- TOKEN_RATIO, 4: words consumed per token toggle. Must divide FIFO_DEPTH.
- CH_WIDTH, 16: bits per channel per io cycle. Fixed so that 2 channels × 2 beats = 64.

Ports:
- clk  in  1  io clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- io_valid_ch0_i  in  1  channel 0 beat valid.
- io_data_ch0_i  in  16  channel 0 beat data.
- io_valid_ch1_i  in  1  channel 1 beat valid.
- io_data_ch1_i  in  16  channel 1 beat data.
- io_token_o  out  1  credit token to upstream; toggles once per TOKEN_RATIO dequeues.
- core_valid_o  out  1  FIFO head valid.
- core_data_o  out  64  FIFO head word.
- core_yumi_i  in  1  core consumes head this cycle; legal only when core_valid_o=1.
- err_overflow_o  out  1  sticky: a word completed while the FIFO was full.
- err_skew_o  out  1  sticky: channel valids disagreed on a cycle.

Behaviour:
- Reset (rst_n=0 sampled at posedge clk):
  - Assembler returns to LOW; FIFO emptied; token counter = 0.
  - io_token_o = 0, core_valid_o = 0, core_data_o = 0, both error flags = 0.
  - Reset mid-word discards the partial half-word. Reset mid-token-count discards the partial count.
- Beat definition: beat = io_valid_ch0_i & io_valid_ch1_i. Beat payload = {io_data_ch1_i, io_data_ch0_i} (32 bits).
- Skew: if exactly one channel valid is high, the cycle is ignored (no beat), err_skew_o is set, and the assembler state is unchanged.
- Assembler FSM, states LOW and HIGH:
  - LOW + beat: capture payload as word[31:0] into the low register; go to HIGH.
  - HIGH + beat: form word = {payload, low register}; push it; go to LOW.
  - No beat: hold state. Gaps between the two halves are allowed for any length.
- Push:
  - Word is visible on core_valid_o/core_data_o the cycle after the completing beat: 1-cycle latency from second beat to core_valid_o when the FIFO was empty.
  - If the FIFO is full and there is no same-cycle yumi: drop the word and set err_overflow_o. The FIFO is unchanged.
  - If the FIFO is full and core_yumi_i=1 in the same cycle: pop and push both succeed and the occupancy is unchanged.
- Pop: core_yumi_i=1 with core_valid_o=1 removes the head. The next head, if any, appears the next cycle.
  - core_yumi_i while empty is ignored and does not affect the token count.
- FIFO: circular, with pointers one bit wider than log2(FIFO_DEPTH).
  - Full: indices equal and MSBs differ.
  - Empty: pointers equal.
  - Pointers wrap modulo 2·FIFO_DEPTH.
- Token:
  - Each successful pop increments tok_cnt (width clog2(TOKEN_RATIO)).
  - On a pop with tok_cnt == TOKEN_RATIO−1: tok_cnt wraps to 0 and io_token_o inverts, registered, visible the next cycle.
  - Only pops generate credit; dropped words generate none.
- Error flags clear only on reset.

Optional Feature:
- Macro: BSG_DOWNSTREAM_RX_STATS_EN.
- With the macro defined:
  - Adds output rx_word_cnt_o [15:0], counting successfully pushed words.
  - The counter saturates at 16'hFFFF and resets to 0.
  - Adds output fifo_level_o [clog2(FIFO_DEPTH):0], the current occupancy.
- Without the macro: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package bsg_downstream_rx_pkg holds:
  - asm_state_e (LOW, HIGH)
  - constants CORE_WIDTH = 64, CH_WIDTH = 16, NUM_CH = 2
  - beat width localparam = NUM_CH·CH_WIDTH
- One sub-module, bsg_downstream_rx_fifo: a synchronous FIFO with push/pop, full/empty, and a level output, parameterized by depth and width.
- Assembler, token logic, and error flags live in the top.

Test Plan:
- Basic word: after reset, beat {0x1111, 0x2222} then beat {0x3333, 0x4444} → next cycle core_valid_o=1, core_data_o=0x3333_4444_1111_2222. Yumi → core_valid_o=0 the following cycle.
- Gap and skew: beat, 3 idle cycles, a cycle with ch0 valid only, then a beat → exactly one word, with halves in order; err_skew_o=1 from the skew cycle onward.
- Token cadence: push 8 words, pop 8 with yumi every cycle → io_token_o toggles 0→1 after pop 4 and 1→0 after pop 8; no other toggles.
- Overflow: with core_yumi_i=0, push 9 words → 8 retained (in order on drain), err_overflow_o=1 after the 9th. Repeat with yumi asserted on the 9th push cycle → no overflow, all 9 delivered.
- Reset mid-operation: 1 half-beat, 3 queued words, tok_cnt=2, then rst_n=0 for 1 cycle → all outputs are at reset values. A fresh 2-beat word emerges intact, and the token toggles only after 4 new pops.
- STATS_EN build: push 5 and pop 2 → rx_word_cnt_o=5, fifo_level_o=3. Force the counter to 16'hFFFF and push 1 → the counter stays at 16'hFFFF.
